// File: rtl/nor_gate_sweep.sv
`default_nettype none
// ============================================================================
// Module   : nor_gate_sweep
// Purpose  : Clocked equivalence sweeper for W-input reduction gates. Every
//            run applies vectors 0..2^W-1, one per cycle. Each vector goes to
//            two versions of the selected gate (OR/NOR/AND/NAND):
//              A - a network of 2-input NOR cells only
//              B - a behavioural De Morgan expression
//            Both results are registered, mismatches are counted, and the
//            run ends with a one-cycle done pulse and a pass flag.
// Ports    : clk              clock, rising edge
//            rst_n            asynchronous active-low reset
//            i_start          run request, sampled in IDLE only
//            i_mode[1:0]      0 OR, 1 NOR, 2 AND, 3 NAND (latched at start)
//            i_fault_en       invert impl A at i_fault_vec (latched at start)
//            i_fault_vec[W-1:0] vector at which impl A is inverted
//            o_busy           run in progress
//            o_valid          o_vec/o_a/o_b carry a fresh result this cycle
//            o_vec[W-1:0]     vector applied
//            o_a, o_b         impl A / impl B result for o_vec
//            o_err_cnt[W:0]   mismatches in the current/last run
//            o_first_err_vec  vector of the first mismatch
//            o_done           one-cycle pulse at end of run
//            o_pass           last completed run had no mismatch
// Revision : 1.0 - initial release
// ============================================================================

// ---------------------------------------------------------------------------
// 2-input NOR primitive. Every gate in impl A is an instance of this cell;
// an inverter is a NOR with both inputs tied together.
// ---------------------------------------------------------------------------
module nor_gate_sweep_nor2 (
  input  logic i_a,
  input  logic i_b,
  output logic o_y
);
  assign o_y = ~(i_a | i_b);
endmodule

// ---------------------------------------------------------------------------
// W-input NOR reduction made from 2-input NOR cells only.
// Internally a balanced OR tree (NOR followed by a NOR inverter per node),
// padded with constant-0 leaves up to a power of two, then a final NOR
// inverter at the root. For W=1 the tree is just the leaf, so the output is
// an inverter of x[0].
// Ports: i_x[W-1:0] operand, o_nor = ~|i_x
// ---------------------------------------------------------------------------
module nor_gate_sweep_nor_tree #(
  parameter int W = 2
) (
  input  logic [W-1:0] i_x,
  output logic         o_nor
);
  localparam int c_DEPTH  = (W > 1) ? $clog2(W) : 0;
  localparam int c_LEAVES = 1 << c_DEPTH;

  // Heap layout: node 1 is the root, node i has children 2i and 2i+1,
  // leaves occupy c_LEAVES..2*c_LEAVES-1. Each node holds the OR of its
  // subtree.
  logic w_node [1:2*c_LEAVES-1];

  genvar gi;
  for (gi = 0; gi < c_LEAVES; gi++) begin : g_leaf
    if (gi < W) begin : g_in
      assign w_node[c_LEAVES+gi] = i_x[gi];
    end else begin : g_pad
      // 0 is the OR identity, so padding leaves do not change the result.
      assign w_node[c_LEAVES+gi] = 1'b0;
    end
  end

  for (gi = 1; gi < c_LEAVES; gi++) begin : g_node
    logic w_nor;
    nor_gate_sweep_nor2 u_nor (
      .i_a (w_node[2*gi]),
      .i_b (w_node[2*gi+1]),
      .o_y (w_nor)
    );
    nor_gate_sweep_nor2 u_inv (
      .i_a (w_nor),
      .i_b (w_nor),
      .o_y (w_node[gi])
    );
  end

  nor_gate_sweep_nor2 u_root (
    .i_a (w_node[1]),
    .i_b (w_node[1]),
    .o_y (o_nor)
  );
endmodule

// ---------------------------------------------------------------------------
// Top level sweeper.
// ---------------------------------------------------------------------------
module nor_gate_sweep #(
  parameter int W = 2   // legal range 1..8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_start,
  input  logic [1:0]   i_mode,
  input  logic         i_fault_en,
  input  logic [W-1:0] i_fault_vec,
  output logic         o_busy,
  output logic         o_valid,
  output logic [W-1:0] o_vec,
  output logic         o_a,
  output logic         o_b,
  output logic [W:0]   o_err_cnt,
  output logic [W-1:0] o_first_err_vec,
  output logic         o_done,
  output logic         o_pass
);

  localparam logic [W:0] c_LAST = {1'b0, {W{1'b1}}};   // N-1
  localparam logic [W:0] c_ONE  = {{W{1'b0}}, 1'b1};

  localparam logic [1:0] c_MODE_OR   = 2'd0;
  localparam logic [1:0] c_MODE_NOR  = 2'd1;
  localparam logic [1:0] c_MODE_AND  = 2'd2;
  localparam logic [1:0] c_MODE_NAND = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t       r_state;
  logic [W:0]   r_cnt;
  logic [1:0]   r_mode;
  logic         r_fault_en;
  logic [W-1:0] r_fault_vec;

  logic         r_busy;
  logic         r_valid;
  logic [W-1:0] r_vec;
  logic         r_a;
  logic         r_b;
  logic [W:0]   r_err_cnt;
  logic [W-1:0] r_first_err_vec;
  logic         r_done;
  logic         r_pass;

  // Vector under test: the low W bits of the counter. The extra counter bit
  // lets the counter step past N-1 without wrapping on the last vector.
  logic [W-1:0] w_x;
  assign w_x = r_cnt[W-1:0];

  // -------------------------------------------------------------------------
  // Impl A: NOR-only network
  // -------------------------------------------------------------------------
  logic [W-1:0] w_xn;
  logic         w_nor_x;    // ~|x
  logic         w_nor_xn;   // ~|~x  == &x
  logic         w_or_a;
  logic         w_nand_a;

  genvar gi;
  for (gi = 0; gi < W; gi++) begin : g_inv
    nor_gate_sweep_nor2 u_inv (
      .i_a (w_x[gi]),
      .i_b (w_x[gi]),
      .o_y (w_xn[gi])
    );
  end

  nor_gate_sweep_nor_tree #(.W(W)) u_tree_x (
    .i_x   (w_x),
    .o_nor (w_nor_x)
  );

  nor_gate_sweep_nor_tree #(.W(W)) u_tree_xn (
    .i_x   (w_xn),
    .o_nor (w_nor_xn)
  );

  nor_gate_sweep_nor2 u_or_inv (
    .i_a (w_nor_x),
    .i_b (w_nor_x),
    .o_y (w_or_a)
  );

  nor_gate_sweep_nor2 u_nand_inv (
    .i_a (w_nor_xn),
    .i_b (w_nor_xn),
    .o_y (w_nand_a)
  );

  logic w_a_gate;
  always_comb begin
    w_a_gate = 1'b0;
    case (r_mode)
      c_MODE_OR:   w_a_gate = w_or_a;
      c_MODE_NOR:  w_a_gate = w_nor_x;
      c_MODE_AND:  w_a_gate = w_nor_xn;
      c_MODE_NAND: w_a_gate = w_nand_a;
      default:     w_a_gate = 1'b0;
    endcase
  end

  // Deliberate corruption of impl A, used to prove the checker catches a
  // wrong answer at a known vector.
  logic w_fault_hit;
  logic w_a;
  assign w_fault_hit = r_fault_en & (w_x == r_fault_vec);
  assign w_a         = w_a_gate ^ w_fault_hit;

  // -------------------------------------------------------------------------
  // Impl B: behavioural De Morgan forms
  // -------------------------------------------------------------------------
  logic w_b;
  always_comb begin
    w_b = 1'b0;
    case (r_mode)
      c_MODE_OR:   w_b = ~(~|w_x);
      c_MODE_NOR:  w_b = ~|w_x;
      c_MODE_AND:  w_b = ~(|(~w_x));
      c_MODE_NAND: w_b = ~(~(|(~w_x)));
      default:     w_b = 1'b0;
    endcase
  end

  logic w_mismatch;
  assign w_mismatch = w_a ^ w_b;

  // -------------------------------------------------------------------------
  // Control FSM with registered outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= S_IDLE;
      r_cnt           <= '0;
      r_mode          <= '0;
      r_fault_en      <= 1'b0;
      r_fault_vec     <= '0;
      r_busy          <= 1'b0;
      r_valid         <= 1'b0;
      r_vec           <= '0;
      r_a             <= 1'b0;
      r_b             <= 1'b0;
      r_err_cnt       <= '0;
      r_first_err_vec <= '0;
      r_done          <= 1'b0;
      r_pass          <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done  <= 1'b0;
          r_valid <= 1'b0;
          // Result registers keep the last run visible until a new start.
          if (i_start) begin
            r_mode          <= i_mode;
            r_fault_en      <= i_fault_en;
            r_fault_vec     <= i_fault_vec;
            r_cnt           <= '0;
            r_err_cnt       <= '0;
            r_first_err_vec <= '0;
            r_pass          <= 1'b0;
            r_busy          <= 1'b1;
            r_state         <= S_RUN;
          end
        end

        S_RUN: begin
          r_vec   <= w_x;
          r_a     <= w_a;
          r_b     <= w_b;
          r_valid <= 1'b1;
          if (w_mismatch) begin
            r_err_cnt <= r_err_cnt + c_ONE;
            if (r_err_cnt == '0) begin
              r_first_err_vec <= w_x;
            end
          end
          r_cnt <= r_cnt + c_ONE;
          if (r_cnt == c_LAST) begin
            r_state <= S_FIN;
          end
        end

        S_FIN: begin
          r_valid <= 1'b0;
          r_done  <= 1'b1;
          r_pass  <= (r_err_cnt == '0);
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_valid <= 1'b0;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_busy          = r_busy;
  assign o_valid         = r_valid;
  assign o_vec           = r_vec;
  assign o_a             = r_a;
  assign o_b             = r_b;
  assign o_err_cnt       = r_err_cnt;
  assign o_first_err_vec = r_first_err_vec;
  assign o_done          = r_done;
  assign o_pass          = r_pass;

endmodule
`default_nettype wire

// File: tb/tb_nor_gate_sweep.sv
`default_nettype none
// ============================================================================
// Module   : tb_nor_gate_sweep
// Purpose  : Self-checking bench for nor_gate_sweep. Three instances (W=1,2,3)
//            share clock and reset; a selector routes stimulus to one of them
//            and muxes its outputs onto common monitor signals. Expected
//            per-vector results are queued when a run is launched and popped
//            by a monitor whenever the DUT reports a valid result.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nor_gate_sweep;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int         sel = 2;
  logic       start = 1'b0;
  logic [1:0] mode = 2'd0;
  logic       fault_en = 1'b0;
  logic [7:0] fault_vec = 8'd0;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0] vec;
    logic       a;
    logic       b;
  } exp_t;

  exp_t sb[$];
  exp_t e_mon;

  // ---------------- DUT instances ----------------
  logic st1, st2, st3;
  assign st1 = start && (sel == 1);
  assign st2 = start && (sel == 2);
  assign st3 = start && (sel == 3);

  logic       busy1, valid1, a1, b1, done1, pass1;
  logic [0:0] vec1, first1;
  logic [1:0] err1;
  logic       busy2, valid2, a2, b2, done2, pass2;
  logic [1:0] vec2, first2;
  logic [2:0] err2;
  logic       busy3, valid3, a3, b3, done3, pass3;
  logic [2:0] vec3, first3;
  logic [3:0] err3;

  nor_gate_sweep #(.W(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .i_start(st1), .i_mode(mode),
    .i_fault_en(fault_en), .i_fault_vec(fault_vec[0:0]),
    .o_busy(busy1), .o_valid(valid1), .o_vec(vec1), .o_a(a1), .o_b(b1),
    .o_err_cnt(err1), .o_first_err_vec(first1), .o_done(done1), .o_pass(pass1)
  );

  nor_gate_sweep #(.W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .i_start(st2), .i_mode(mode),
    .i_fault_en(fault_en), .i_fault_vec(fault_vec[1:0]),
    .o_busy(busy2), .o_valid(valid2), .o_vec(vec2), .o_a(a2), .o_b(b2),
    .o_err_cnt(err2), .o_first_err_vec(first2), .o_done(done2), .o_pass(pass2)
  );

  nor_gate_sweep #(.W(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .i_start(st3), .i_mode(mode),
    .i_fault_en(fault_en), .i_fault_vec(fault_vec[2:0]),
    .o_busy(busy3), .o_valid(valid3), .o_vec(vec3), .o_a(a3), .o_b(b3),
    .o_err_cnt(err3), .o_first_err_vec(first3), .o_done(done3), .o_pass(pass3)
  );

  // ---------------- output selector ----------------
  logic       m_busy, m_valid, m_a, m_b, m_done, m_pass;
  logic [7:0] m_vec, m_first;
  logic [8:0] m_err;

  always_comb begin
    m_busy = 1'b0; m_valid = 1'b0; m_a = 1'b0; m_b = 1'b0;
    m_done = 1'b0; m_pass = 1'b0; m_vec = '0; m_first = '0; m_err = '0;
    case (sel)
      1: begin
        m_busy = busy1; m_valid = valid1; m_a = a1; m_b = b1; m_done = done1;
        m_pass = pass1; m_vec = 8'(vec1); m_first = 8'(first1); m_err = 9'(err1);
      end
      2: begin
        m_busy = busy2; m_valid = valid2; m_a = a2; m_b = b2; m_done = done2;
        m_pass = pass2; m_vec = 8'(vec2); m_first = 8'(first2); m_err = 9'(err2);
      end
      3: begin
        m_busy = busy3; m_valid = valid3; m_a = a3; m_b = b3; m_done = done3;
        m_pass = pass3; m_vec = 8'(vec3); m_first = 8'(first3); m_err = 9'(err3);
      end
      default: ;
    endcase
  end

  // ---------------- reference model ----------------
  function automatic logic model(input logic [1:0] md, input int w, input int v);
    logic any_one;
    logic all_one;
    any_one = (v != 0);
    all_one = (v == (1 << w) - 1);
    case (md)
      2'd0:    return any_one;
      2'd1:    return !any_one;
      2'd2:    return all_one;
      default: return !all_one;
    endcase
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(posedge clk) begin
    #1;
    if (m_valid) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected got vec=%0d a=%b b=%b required no result", m_vec, m_a, m_b);
      end else begin
        e_mon = sb.pop_front();
        if ({m_vec, m_a, m_b} !== {e_mon.vec, e_mon.a, e_mon.b}) begin
          errors++;
          $display("FAIL sb_result got vec=%0d a=%b b=%b required vec=%0d a=%b b=%b",
                   m_vec, m_a, m_b, e_mon.vec, e_mon.a, e_mon.b);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic push_run(input int w, input logic [1:0] md, input logic fen, input logic [7:0] fv);
    exp_t e;
    for (int v = 0; v < (1 << w); v++) begin
      e.vec = 8'(v);
      e.b   = model(md, w, v);
      e.a   = e.b ^ (fen && (v == int'(fv)));
      sb.push_back(e);
    end
  endtask

  // Launch a run and wait for done; cyc = edges after the start edge.
  task automatic do_run(input int w, input logic [1:0] md, input logic fen,
                        input logic [7:0] fv, output int cyc);
    sel = w;
    push_run(w, md, fen, fv);
    @(negedge clk);
    start = 1'b1; mode = md; fault_en = fen; fault_vec = fv;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (m_done) break;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    for (int s = 1; s <= 3; s++) begin
      sel = s;
      #1;
      checks++;
      if ({m_busy, m_valid, m_vec, m_a, m_b, m_err, m_first, m_done, m_pass} !== '0) begin
        errors++;
        $display("FAIL reset_w%0d got %h required 0", s,
                 {m_busy, m_valid, m_vec, m_a, m_b, m_err, m_first, m_done, m_pass});
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    sel = 2;
  endtask

  task automatic test_or_w2;
    int cyc;
    do_run(2, 2'd0, 1'b0, 8'd0, cyc);
    checks++; if (cyc !== 5) begin errors++; $display("FAIL or_latency got %0d required 5", cyc); end
    checks++; if (m_err !== 9'd0) begin errors++; $display("FAIL or_err got %0d required 0", m_err); end
    checks++; if (m_pass !== 1'b1) begin errors++; $display("FAIL or_pass got %b required 1", m_pass); end
    checks++; if ({m_busy, m_valid} !== 2'b00) begin errors++; $display("FAIL or_busy_valid got %b required 00", {m_busy, m_valid}); end
    @(posedge clk); #1;
    checks++; if (m_done !== 1'b0) begin errors++; $display("FAIL or_done_width got %b required 0", m_done); end
    checks++; if (m_pass !== 1'b1) begin errors++; $display("FAIL or_pass_hold got %b required 1", m_pass); end
  endtask

  task automatic test_nor_fault;
    int cyc;
    do_run(2, 2'd1, 1'b1, 8'd2, cyc);
    checks++; if (cyc !== 5) begin errors++; $display("FAIL nor_latency got %0d required 5", cyc); end
    checks++; if (m_err !== 9'd1) begin errors++; $display("FAIL nor_err got %0d required 1", m_err); end
    checks++; if (m_first !== 8'd2) begin errors++; $display("FAIL nor_first got %0d required 2", m_first); end
    checks++; if (m_pass !== 1'b0) begin errors++; $display("FAIL nor_pass got %b required 0", m_pass); end
  endtask

  task automatic test_nand_w3;
    int cyc;
    do_run(3, 2'd3, 1'b0, 8'd0, cyc);
    checks++; if (cyc !== 9) begin errors++; $display("FAIL nand_latency got %0d required 9", cyc); end
    checks++; if (m_err !== 9'd0) begin errors++; $display("FAIL nand_err got %0d required 0", m_err); end
    checks++; if (m_pass !== 1'b1) begin errors++; $display("FAIL nand_pass got %b required 1", m_pass); end
  endtask

  task automatic test_back_to_back;
    int cyc;
    sel = 2;
    push_run(2, 2'd2, 1'b1, 8'd1);
    @(negedge clk);
    start = 1'b1; mode = 2'd2; fault_en = 1'b1; fault_vec = 8'd1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (m_busy !== 1'b1) begin errors++; $display("FAIL b2b_busy got %b required 1", m_busy); end
    // Mid-run start and configuration changes must be ignored.
    @(negedge clk);
    start = 1'b1; mode = 2'd0; fault_en = 1'b0; fault_vec = 8'd3;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    while (cyc < 200 && !m_done) begin
      @(posedge clk); #1;
      cyc++;
    end
    checks++; if (cyc !== 5) begin errors++; $display("FAIL b2b_latency got %0d required 5", cyc); end
    checks++; if (m_err !== 9'd1) begin errors++; $display("FAIL b2b_err got %0d required 1", m_err); end
    checks++; if (m_first !== 8'd1) begin errors++; $display("FAIL b2b_first got %0d required 1", m_first); end
    // Start issued during the done cycle is accepted.
    push_run(2, 2'd2, 1'b0, 8'd0);
    start = 1'b1; mode = 2'd2; fault_en = 1'b0; fault_vec = 8'd0;
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if ({m_busy, m_done} !== 2'b10) begin errors++; $display("FAIL b2b_restart got busy,done=%b required 10", {m_busy, m_done}); end
    checks++; if (m_err !== 9'd0) begin errors++; $display("FAIL b2b_err_clear got %0d required 0", m_err); end
    cyc = 0;
    while (cyc < 200 && !m_done) begin
      @(posedge clk); #1;
      cyc++;
    end
    checks++; if (cyc !== 5) begin errors++; $display("FAIL b2b_latency2 got %0d required 5", cyc); end
    checks++; if (m_pass !== 1'b1) begin errors++; $display("FAIL b2b_pass got %b required 1", m_pass); end
  endtask

  task automatic test_async_reset;
    int n;
    int cyc;
    logic seen;
    sel = 2;
    push_run(2, 2'd0, 1'b0, 8'd0);
    @(negedge clk);
    start = 1'b1; mode = 2'd0; fault_en = 1'b0; fault_vec = 8'd0;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (n < 20 && !(m_valid && m_vec == 8'd1)) begin
      @(posedge clk); #1;
      n++;
    end
    checks++; if (n >= 20) begin errors++; $display("FAIL rst_wait got timeout required vec 1"); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({m_busy, m_valid, m_vec, m_a, m_b, m_err, m_first, m_done, m_pass} !== '0) begin
      errors++;
      $display("FAIL rst_async got %h required 0",
               {m_busy, m_valid, m_vec, m_a, m_b, m_err, m_first, m_done, m_pass});
    end
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (m_done) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rst_no_done got done=1 required 0"); end
    do_run(2, 2'd0, 1'b0, 8'd0, cyc);
    checks++; if (cyc !== 5) begin errors++; $display("FAIL rst_rerun_latency got %0d required 5", cyc); end
    checks++; if (m_pass !== 1'b1) begin errors++; $display("FAIL rst_rerun_pass got %b required 1", m_pass); end
  endtask

  task automatic test_w1_fault;
    int cyc;
    do_run(1, 2'd0, 1'b1, 8'd0, cyc);
    checks++; if (cyc !== 3) begin errors++; $display("FAIL w1a_latency got %0d required 3", cyc); end
    checks++; if (m_err !== 9'd1) begin errors++; $display("FAIL w1a_err got %0d required 1", m_err); end
    checks++; if (m_first !== 8'd0) begin errors++; $display("FAIL w1a_first got %0d required 0", m_first); end
    checks++; if (m_pass !== 1'b0) begin errors++; $display("FAIL w1a_pass got %b required 0", m_pass); end
    do_run(1, 2'd0, 1'b1, 8'd1, cyc);
    checks++; if (m_err !== 9'd1) begin errors++; $display("FAIL w1b_err got %0d required 1", m_err); end
    checks++; if (m_first !== 8'd1) begin errors++; $display("FAIL w1b_first got %0d required 1", m_first); end
    checks++; if (m_pass !== 1'b0) begin errors++; $display("FAIL w1b_pass got %b required 0", m_pass); end
  endtask

  initial begin
    test_reset();
    test_or_w2();
    test_nor_fault();
    test_nand_w3();
    test_back_to_back();
    test_async_reset();
    test_w1_fault();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover got %0d entries required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/nor_gate_sweep.md
# nor_gate_sweep

- Parametrised, clocked equivalence sweeper for W-input reduction gates.
- Each run drives every input vector 0..2^W-1, one per cycle, into two implementations of the selected gate function:
  - Impl A: a network built only from 2-input NOR primitives.
  - Impl B: a behavioural De Morgan expression.
- Registers both results per vector, counts mismatches, reports pass/fail with a done pulse.
- Sits in the gate-exercise library as the self-checking, multi-mode, W-wide successor of the fixed 2-input OR-from-NOR pair.

## Interface

Parameters:
- W, default 2: gate input width. Legal range 1..8. N = 2^W vectors per run.

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  run request; sampled only in IDLE
- mode  in  2  gate function: 0 OR, 1 NOR, 2 AND, 3 NAND; latched at start
- fault_en  in  1  enables fault injection on impl A; latched at start
- fault_vec  in  W  vector at which impl A output is inverted; latched at start
- busy  out  1  run in progress
- valid  out  1  vec_out/a_out/b_out hold a fresh vector result this cycle
- vec_out  out  W  vector applied
- a_out  out  1  impl A (NOR-only) result for vec_out
- b_out  out  1  impl B (behavioural) result for vec_out
- err_cnt  out  W+1  mismatches in current/last run; max N, cannot overflow
- first_err_vec  out  W  vector of first mismatch in current/last run
- done  out  1  one-cycle pulse at end of run
- pass  out  1  last completed run had err_cnt==0

## Operation

Impl A structure per mode, with W-input reductions built as NOR trees plus NOR inverters (nor with both inputs tied):
- OR = inverted NOR tree.
- NOR = NOR tree.
- AND = NOR tree of inverted inputs.
- NAND = inverted AND.
- W=1: reductions degenerate to buffer/inverter of x[0].

Impl B: `~(~|x)`, `~|x`, `~(|~x)`, `~(~(|~x))` respectively.

Fault: when the latched fault_en=1 and the current vector equals the latched fault_vec, the impl A result is inverted before registering.

FSM states:
- IDLE
  - start=1 -> RUN.
  - Latch mode/fault_en/fault_vec; cnt<=0; err_cnt<=0; first_err_vec<=0; pass<=0.
- RUN
  - Each edge: vec_out<=cnt, a_out<=A(cnt), b_out<=B(cnt), valid<=1.
  - If A(cnt)!=B(cnt): err_cnt++; if err_cnt was 0, first_err_vec<=cnt.
  - cnt++.
  - At cnt==N-1 -> FIN.
- FIN
  - valid<=0, done<=1, pass<=(err_cnt==0).
  - -> IDLE.

Rules:
- start while busy is ignored; mode/fault inputs are ignored outside start acceptance.
- start in the cycle done is high is accepted (state is IDLE).
- cnt is W+1 bits internally; vec_out is its low W bits.
- err_cnt, first_err_vec, a_out, b_out, vec_out hold their values after the run until the next accepted start.

## Timing

- Reset values: busy 0, valid 0, vec_out 0, a_out 0, b_out 0, err_cnt 0, first_err_vec 0, done 0, pass 0; state IDLE.
- Edge E0 accepts start. After E0: busy=1.
- After Ek (k=1..N): valid=1, vec_out=k-1. Latency from start edge to first result is 1 cycle.
- After EN: err_cnt is final.
- After E(N+1): done=1 for exactly one cycle, busy=0, valid=0, pass valid.
- Total run: N+1 cycles from start edge to done.
- rst_n low at any time, including mid-run, forces reset values immediately. No done is produced for an aborted run.
- rst_n deassertion is synchronised externally; the block has no internal reset synchroniser.

## Test plan

- W=2, mode=0, no fault, start 1 cycle: a_out=b_out sequence 0,1,1,1 on vec 0..3; done 5 cycles after start edge; err_cnt=0, pass=1.
- W=2, mode=1, fault_en=1, fault_vec=2:
  - b sequence 1,0,0,0; a_out=1 at vec 2.
  - err_cnt=1, first_err_vec=2, pass=0.
- W=3, mode=3, no fault: b_out=1 for vec 0..6, 0 at vec 7; err_cnt=0; done 9 cycles after start.
- W=2, mode=2: start pulsed again mid-run and mode changed mid-run.
  - Both are ignored; the single run yields AND sequence 0,0,0,1.
  - The next start issued in the done cycle is accepted, and err_cnt clears.
- W=2: rst_n pulsed low after vec 1 is output.
  - All outputs go to 0 immediately; no done pulse.
  - A fresh start runs normally from vec 0.
- W=1, mode=0, fault_en=1, fault_vec=0, then fault_vec=1: err_cnt=1, first_err_vec=0, then first_err_vec=1; pass=0 both runs.
